morse_decoder_basic: RTL and testbench

- Receive-side counterpart of the switch-driven Morse encoder: samples a single Morse key input and times each press as dot or dash.
- Assembles the elements of one character and emits a 6-bit character code once the inter-character gap has elapsed.
- Keeps an 8-character history for the seven-segment display path.
- Sits between the debounced key button and the display/translation logic.

---
 rtl/morse_decoder_basic.sv | 202 ++++++++++++++++++++
 tb/tb_morse_decoder_basic.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/morse_decoder_basic.sv
// rtl/morse_decoder_basic.sv - Morse key decoder: times presses into dots/dashes and emits character codes
//
// Purpose: samples a Morse key, classifies each press as dot or dash on a
// tick timebase, closes a character after a key-released gap and emits a
// 6-bit character code. An 8-deep code history feeds the display path.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-low reset
//   en            decoder enable; low forces IDLE and drops any partial character
//   key           Morse key, 1 = pressed, asynchronous to clk
//   clr           synchronous clear of char_hist and overflow
//   char_valid    one-clk pulse when a character is emitted
//   char_code     0-25 = A-Z, 26-35 = 0-9, 63 = invalid
//   morse_pattern element bits of emitted character, bit i = element i, 1 = dash
//   morse_len     element count of emitted character
//   char_hist     last 8 codes, [5:0] newest, empty slots 63
//   overflow      sticky, set when a character exceeds 5 elements
module morse_decoder_basic #(
   parameter int TICK_DIV        = 100000,
   parameter int MIN_PRESS_TICKS = 20,
   parameter int DASH_TICKS      = 200,
   parameter int CHAR_GAP_TICKS  = 400
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        key,
   input  logic        clr,
   output logic        char_valid,
   output logic [5:0]  char_code,
   output logic [4:0]  morse_pattern,
   output logic [2:0]  morse_len,
   output logic [47:0] char_hist,
   output logic        overflow
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [15:0]   MIN_P     = 16'(MIN_PRESS_TICKS);
   localparam logic [15:0]   DASH_P    = 16'(DASH_TICKS);
   localparam logic [15:0]   GAP_P     = 16'(CHAR_GAP_TICKS);

   typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP, S_EMIT} state_t;

   state_t        state, state_nxt;
   logic          key_s1, key_s2;
   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic [15:0]   press_cnt, gap_cnt;
   logic [4:0]    work_pat;
   logic [2:0]    work_len;
   logic          work_inv;
   logic          press_ok, is_dash, emit_now;
   logic [5:0]    code_nxt;

   // ITU lookup; element 0 sits in bit 0, dash = 1.
   function automatic logic [5:0] lookup(input logic [2:0] len, input logic [4:0] pat);
      case ({len, pat})
         {3'd2, 5'b00010}: lookup = 6'd0;   // A
         {3'd4, 5'b00001}: lookup = 6'd1;   // B
         {3'd4, 5'b00101}: lookup = 6'd2;   // C
         {3'd3, 5'b00001}: lookup = 6'd3;   // D
         {3'd1, 5'b00000}: lookup = 6'd4;   // E
         {3'd4, 5'b00100}: lookup = 6'd5;   // F
         {3'd3, 5'b00011}: lookup = 6'd6;   // G
         {3'd4, 5'b00000}: lookup = 6'd7;   // H
         {3'd2, 5'b00000}: lookup = 6'd8;   // I
         {3'd4, 5'b01110}: lookup = 6'd9;   // J
         {3'd3, 5'b00101}: lookup = 6'd10;  // K
         {3'd4, 5'b00010}: lookup = 6'd11;  // L
         {3'd2, 5'b00011}: lookup = 6'd12;  // M
         {3'd2, 5'b00001}: lookup = 6'd13;  // N
         {3'd3, 5'b00111}: lookup = 6'd14;  // O
         {3'd4, 5'b00110}: lookup = 6'd15;  // P
         {3'd4, 5'b01011}: lookup = 6'd16;  // Q
         {3'd3, 5'b00010}: lookup = 6'd17;  // R
         {3'd3, 5'b00000}: lookup = 6'd18;  // S
         {3'd1, 5'b00001}: lookup = 6'd19;  // T
         {3'd3, 5'b00100}: lookup = 6'd20;  // U
         {3'd4, 5'b01000}: lookup = 6'd21;  // V
         {3'd3, 5'b00110}: lookup = 6'd22;  // W
         {3'd4, 5'b01001}: lookup = 6'd23;  // X
         {3'd4, 5'b01101}: lookup = 6'd24;  // Y
         {3'd4, 5'b00011}: lookup = 6'd25;  // Z
         {3'd5, 5'b11111}: lookup = 6'd26;  // 0
         {3'd5, 5'b11110}: lookup = 6'd27;  // 1
         {3'd5, 5'b11100}: lookup = 6'd28;  // 2
         {3'd5, 5'b11000}: lookup = 6'd29;  // 3
         {3'd5, 5'b10000}: lookup = 6'd30;  // 4
         {3'd5, 5'b00000}: lookup = 6'd31;  // 5
         {3'd5, 5'b00001}: lookup = 6'd32;  // 6
         {3'd5, 5'b00011}: lookup = 6'd33;  // 7
         {3'd5, 5'b00111}: lookup = 6'd34;  // 8
         {3'd5, 5'b01111}: lookup = 6'd35;  // 9
         default:          lookup = 6'd63;
      endcase
   endfunction

   assign tick     = en && (tick_cnt == TICK_LAST);
   assign press_ok = (press_cnt >= MIN_P);
   assign is_dash  = (press_cnt >= DASH_P);
   // Outputs are loaded on the edge entering EMIT so they are already
   // valid while char_valid is high.
   assign emit_now = en && (state == S_GAP) && !key_s2 && (gap_cnt == GAP_P);
   assign code_nxt = work_inv ? 6'd63 : lookup(work_len, work_pat);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_s1   <= 1'b0;
         key_s2   <= 1'b0;
         tick_cnt <= '0;
      end else begin
         key_s1   <= key;
         key_s2   <= key_s1;
         tick_cnt <= (!en || tick) ? '0 : tick_cnt + 1'b1;
      end
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (key_s2) state_nxt = S_PRESS;
         S_PRESS: if (!key_s2) state_nxt = (press_ok || work_len != 3'd0) ? S_GAP : S_IDLE;
         S_GAP:   if (key_s2) state_nxt = S_PRESS;
                  else if (gap_cnt == GAP_P) state_nxt = S_EMIT;
         S_EMIT:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (!en) state_nxt = S_IDLE;
   end

   // FSM: outputs
   always_comb begin
      char_valid = en && (state == S_EMIT);
   end

   // Datapath: counters, working character, emitted outputs, history
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         press_cnt     <= '0;
         gap_cnt       <= '0;
         work_pat      <= '0;
         work_len      <= '0;
         work_inv      <= 1'b0;
         char_code     <= 6'd63;
         morse_pattern <= '0;
         morse_len     <= '0;
         char_hist     <= {48{1'b1}};
         overflow      <= 1'b0;
      end else begin
         if (!en || state == S_IDLE || state == S_EMIT) begin
            press_cnt <= '0;
            gap_cnt   <= '0;
            work_pat  <= '0;
            work_len  <= '0;
            work_inv  <= 1'b0;
         end else if (state == S_PRESS) begin
            if (key_s2) begin
               if (tick && press_cnt != 16'hFFFF) press_cnt <= press_cnt + 16'd1;
            end else begin
               gap_cnt <= '0;
               if (press_ok) begin
                  if (work_len == 3'd5) begin
                     overflow <= 1'b1;
                     work_inv <= 1'b1;
                  end else begin
                     work_pat <= work_pat | (5'(is_dash) << work_len);
                     work_len <= work_len + 3'd1;
                  end
               end
            end
         end else if (state == S_GAP) begin
            if (key_s2) begin
               press_cnt <= '0;
               gap_cnt   <= '0;
            end else if (tick && gap_cnt != GAP_P && gap_cnt != 16'hFFFF) begin
               gap_cnt <= gap_cnt + 16'd1;
            end
         end
         if (emit_now) begin
            char_code     <= code_nxt;
            morse_pattern <= work_pat;
            morse_len     <= work_len;
            char_hist     <= {char_hist[41:0], code_nxt};
         end
         // clr overrides a coincident history shift or overflow set.
         if (clr) begin
            char_hist <= {48{1'b1}};
            overflow  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_morse_decoder_basic.sv
// tb/tb_morse_decoder_basic.sv - scoreboard bench for morse_decoder_basic
module tb_morse_decoder_basic;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        key = 1'b0;
   logic        clr = 1'b0;
   logic        char_valid;
   logic [5:0]  char_code;
   logic [4:0]  morse_pattern;
   logic [2:0]  morse_len;
   logic [47:0] char_hist;
   logic        overflow;

   localparam logic [47:0] ALL63 = {48{1'b1}};

   morse_decoder_basic #(
      .TICK_DIV(1), .MIN_PRESS_TICKS(2), .DASH_TICKS(4), .CHAR_GAP_TICKS(8)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .key(key), .clr(clr),
      .char_valid(char_valid), .char_code(char_code),
      .morse_pattern(morse_pattern), .morse_len(morse_len),
      .char_hist(char_hist), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] code;
      logic [4:0] pat;
      logic [2:0] len;
      logic       ovf;
   } exp_t;

   exp_t        exp_q[$];
   int          n_chk = 0;
   int          n_err = 0;
   int          n_emit = 0;
   logic [47:0] model_hist = ALL63;
   logic        model_ovf = 1'b0;

   task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor: compare every emitted character against the scoreboard head.
   always @(posedge clk) begin
      #1;
      if (char_valid) begin
         n_emit++;
         if (exp_q.size() == 0) begin
            chk("unexpected_emit", 48'(char_code), 48'd99);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.ovf) model_ovf = 1'b1;
            model_hist = {model_hist[41:0], e.code};
            chk("char_code", 48'(char_code), 48'(e.code));
            chk("morse_pattern", 48'(morse_pattern), 48'(e.pat));
            chk("morse_len", 48'(morse_len), 48'(e.len));
            chk("char_hist", char_hist, model_hist);
            chk("overflow", 48'(overflow), 48'(model_ovf));
         end
      end
   end

   task automatic push(input logic [5:0] code, input logic [4:0] pat, input logic [2:0] len, input logic ovf);
      exp_t e;
      e.code = code; e.pat = pat; e.len = len; e.ovf = ovf;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Dot = key held 3 clk, dash = 6 clk, glitch = 1 clk, intra-char gap = 3 clk.
   task automatic press(input int n);
      @(negedge clk) key = 1'b1;
      idle(n);
      key = 1'b0;
   endtask

   task automatic send(input logic [7:0] dashes, input int n);
      for (int i = 0; i < n; i++) begin
         press(dashes[i] ? 6 : 3);
         if (i < n - 1) idle(3);
      end
   endtask

   task automatic wait_emit(input int prev);
      int k;
      k = 0;
      while (n_emit == prev && k < 60) begin
         @(negedge clk);
         k++;
      end
      chk("emit_count", 48'(n_emit), 48'(prev + 1));
      idle(3);
   endtask

   task automatic expect_quiet(input string tag, input int n);
      int prev;
      prev = n_emit;
      idle(n);
      chk(tag, 48'(n_emit), 48'(prev));
   endtask

   initial begin
      int prev;
      idle(3);
      chk("rst_code", 48'(char_code), 48'd63);
      chk("rst_hist", char_hist, ALL63);
      chk("rst_valid", 48'(char_valid), 48'd0);
      chk("rst_ovf", 48'(overflow), 48'd0);
      chk("rst_len", 48'(morse_len), 48'd0);
      rst = 1'b1;
      en = 1'b1;
      idle(2);

      // A: dot dash
      prev = n_emit; push(6'd0, 5'b00010, 3'd2, 1'b0); send(8'b10, 2); wait_emit(prev);
      chk("a_hist_low", 48'(char_hist[5:0]), 48'd0);
      // 0: five dashes
      prev = n_emit; push(6'd26, 5'b11111, 3'd5, 1'b0); send(8'b11111, 5); wait_emit(prev);
      // six dots: overflow, invalid
      prev = n_emit; push(6'd63, 5'b00000, 3'd5, 1'b1); send(8'b000000, 6); wait_emit(prev);
      chk("ovf_sticky", 48'(overflow), 48'd1);

      // lone glitch: nothing emitted
      press(1);
      expect_quiet("glitch_no_emit", 30);

      // dot, glitch, dot -> I
      prev = n_emit; push(6'd8, 5'b00000, 3'd2, 1'b0);
      press(3); idle(3); press(1); idle(3); press(3);
      wait_emit(prev);

      // E T E
      prev = n_emit; push(6'd4, 5'b00000, 3'd1, 1'b0); send(8'b0, 1); wait_emit(prev);
      prev = n_emit; push(6'd19, 5'b00001, 3'd1, 1'b0); send(8'b1, 1); wait_emit(prev);
      prev = n_emit; push(6'd4, 5'b00000, 3'd1, 1'b0); send(8'b0, 1); wait_emit(prev);
      chk("ete_hist", 48'(char_hist[17:0]), 48'({6'd4, 6'd19, 6'd4}));

      @(negedge clk) clr = 1'b1;
      @(negedge clk) clr = 1'b0;
      model_hist = ALL63;
      model_ovf = 1'b0;
      chk("clr_hist", char_hist, ALL63);
      chk("clr_ovf", 48'(overflow), 48'd0);

      // reset in the middle of a press
      @(negedge clk) key = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(2);
      key = 1'b0;
      rst = 1'b1;
      expect_quiet("rst_mid_no_emit", 30);
      chk("rst_mid_code", 48'(char_code), 48'd63);
      prev = n_emit; push(6'd19, 5'b00001, 3'd1, 1'b0); send(8'b1, 1); wait_emit(prev);

      // drop en in the middle of a dash
      @(negedge clk) key = 1'b1;
      idle(4);
      en = 1'b0;
      idle(3);
      key = 1'b0;
      idle(2);
      en = 1'b1;
      expect_quiet("en_mid_no_emit", 30);
      chk("en_hold_code", 48'(char_code), 48'd19);
      chk("en_hold_len", 48'(morse_len), 48'd1);
      prev = n_emit; push(6'd19, 5'b00001, 3'd1, 1'b0); send(8'b1, 1); wait_emit(prev);

      chk("sb_empty", 48'(exp_q.size()), 48'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
